// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider controller.
//   state_t            : controller FSM state (IDLE, CALC, DONE), 2-bit encoded
//   DIV_WIDTH_DEFAULT  : default operand/quotient/remainder width
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
// Ports:
//   pr       in  WIDTH+1  partial remainder before this step
//   dbit     in  1        next dividend bit (MSB first)
//   divisor  in  WIDTH    divisor, unsigned
//   pr_next  out WIDTH+1  partial remainder after this step
//   qbit     out 1        quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   pr,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   pr_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dext;

    always_comb begin
        shifted = {pr[WIDTH-1:0], dbit};
        dext    = {1'b0, divisor};
        // pr[WIDTH] is zero whenever pr < divisor holds. If it were ever set,
        // the true shifted value would exceed any divisor, so subtracting is
        // still the arithmetically right answer.
        qbit    = pr[WIDTH] || (shifted >= dext);
        pr_next = qbit ? (shifted - dext) : shifted;
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// ----------------------------------------------------------------------------
// div_seq_ctrl
// Multi-cycle restoring divider controller: one quotient bit per clock.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_valid/ready request handshake carrying dividend a / divisor b
//   a, b              WIDTH-bit unsigned operands, latched on acceptance
//   res_valid/ready   result handshake carrying quot/rem/div_by_zero
//   quot, rem         registered quotient / remainder
//   div_by_zero       set when the divisor of this result was zero
//   busy              high in CALC or DONE
//   dbg_state         current FSM state, for observation only
//
// Handshake rule (both interfaces): a transfer happens at a rising edge where
// valid && ready are both high. start_ready depends only on the state and
// res_valid depends only on the state, so no input reaches any output
// combinationally. A request is accepted only in IDLE; there is no restart
// in the same cycle a result is taken.
// ----------------------------------------------------------------------------
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;

    // a_sh holds the latched dividend, shifted left each step so the bit
    // being consumed is always at the MSB.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH:0]   pr;
    logic [CW-1:0]    idx;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   step_pr;
    logic             step_q;
    logic [WIDTH-1:0] q_final;

    assign accept    = start_valid && (state == IDLE);
    assign last_step = (idx == '0);
    assign q_final   = {q_acc[WIDTH-2:0], step_q};

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr),
        .dbit    (a_sh[WIDTH-1]),
        .divisor (b_lat),
        .pr_next (step_pr),
        .qbit    (step_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (accept) begin
                    state_next = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh        <= '0;
            b_lat       <= '0;
            q_acc       <= '0;
            pr          <= '0;
            idx         <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_lat <= b;
                        q_acc <= '0;
                        pr    <= '0;
                        idx   <= CW'(WIDTH - 1);
                        // Divide by zero skips iteration and reports at once.
                        if (b == '0) begin
                            quot        <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    pr    <= step_pr;
                    q_acc <= q_final;
                    a_sh  <= {a_sh[WIDTH-2:0], 1'b0};
                    idx   <= idx - CW'(1);
                    if (last_step) begin
                        quot        <= q_final;
                        rem         <= step_pr[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds the result until it is taken.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;
  logic         busy;
  state_t       dbg_state;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // standalone step unit
  logic [W:0]   st_pr;
  logic         st_bit;
  logic [W-1:0] st_d;
  logic [W:0]   st_pr_next;
  logic         st_q;

  div_step #(.WIDTH(W)) u_step_ut (
    .pr      (st_pr),
    .dbit    (st_bit),
    .divisor (st_d),
    .pr_next (st_pr_next),
    .qbit    (st_q)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Counts edges from the acceptance edge (inclusive) until res_valid is seen.
  task automatic wait_res(output int n);
    n = 1;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    check("idle_start_ready", start_ready, 1);
    a = v.a; b = v.b; start_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = ~v.a; b = ~v.b;
    check("busy_after_accept", busy, 1);
    wait_res(n);
    check("latency", n, v.lat);
    check("quot", quot, v.q);
    check("rem", rem, v.r);
    check("div_by_zero", div_by_zero, v.z);
    check("start_ready_in_done", start_ready, 0);
    @(negedge clk);
    check("ready_after_take", start_ready, 1);
    check("res_valid_drop", res_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int guard;
    int got;
    bit drv_done;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    st_pr = '0; st_bit = 1'b0; st_d = '0;

    // div_step unit test over its valid domain (pr < divisor)
    for (int d = 1; d < 16; d++) begin
      for (int p = 0; p < d; p++) begin
        for (int bt = 0; bt < 2; bt++) begin
          int v;
          int eq;
          st_pr = (W+1)'(p); st_bit = bt[0]; st_d = W'(d);
          #1;
          v = 2 * p + bt;
          eq = (v >= d) ? 1 : 0;
          checks++;
          if (st_q !== eq[0] || st_pr_next !== (W+1)'(eq ? v - d : v)) begin
            failures++;
            $display("FAIL div_step: pr=%0d bit=%0d d=%0d got q=%0d pr=%0d expected q=%0d pr=%0d",
                     p, bt, d, st_q, st_pr_next, eq, eq ? v - d : v);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_start_ready", start_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // table: a, b, quot, rem, dbz, latency
    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, z: 1'b0, lat: 5};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0, lat: 5};
    vecs[2] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3, z: 1'b0, lat: 5};
    vecs[3] = '{a: 4'd7,  b: 4'd0,  q: 4'hF,  r: 4'd7, z: 1'b1, lat: 1};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  q: 4'hF,  r: 4'd0, z: 1'b1, lat: 1};
    vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0, lat: 5};
    vecs[6] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0, lat: 5};
    vecs[7] = '{a: 4'd8,  b: 4'd3,  q: 4'd2,  r: 4'd2, z: 1'b0, lat: 5};
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // back-to-back with start_valid held high
    @(negedge clk);
    a = 4'd15; b = 4'd1; start_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    a = 4'd3; b = 4'd9;
    wait_res(n);
    check("b2b_first_lat", n, 5);
    check("b2b_first_quot", quot, 15);
    check("b2b_first_rem", rem, 0);
    @(negedge clk);
    check("b2b_idle_gap", dbg_state, IDLE);
    check("b2b_ready_gap", start_ready, 1);
    @(negedge clk);
    check("b2b_second_accepted", dbg_state, CALC);
    start_valid = 1'b0;
    wait_res(n);
    check("b2b_second_lat", n, 5);
    check("b2b_second_quot", quot, 0);
    check("b2b_second_rem", rem, 3);
    @(negedge clk);

    // backpressure: result held stable
    a = 4'd14; b = 4'd3; start_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    wait_res(n);
    for (int k = 0; k < 10; k++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_quot", quot, 4);
      check("bp_rem", rem, 2);
      check("bp_start_ready", start_ready, 0);
      start_valid = k[0];
      a = W'(k); b = W'(k + 1);
      @(negedge clk);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", dbg_state, IDLE);
    check("bp_release_ready", start_ready, 1);

    // reset in the middle of CALC
    a = 4'd9; b = 4'd2; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    check("abort_in_calc", dbg_state, CALC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", dbg_state, IDLE);
    check("abort_start_ready", start_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_dbz", div_by_zero, 0);
    run_vec('{a: 4'd9, b: 4'd2, q: 4'd4, r: 4'd1, z: 1'b0, lat: 5});

    // exhaustive with random backpressure and start_valid noise while busy
    got = 0;
    drv_done = 1'b0;
    fork
      begin : driver
        for (int ia = 0; ia < 16; ia++) begin
          for (int ib = 0; ib < 16; ib++) begin
            guard = 0;
            @(negedge clk);
            while (!start_ready && guard < 500) begin
              start_valid = 1'(($urandom_range(0, 1)));
              a = W'($urandom_range(0, 15));
              b = W'($urandom_range(0, 15));
              @(negedge clk);
              guard++;
            end
            if (!start_ready) begin
              checks++;
              failures++;
              $display("FAIL ex_accept_timeout: start_ready=0 expected 1 for a=%0d b=%0d", ia, ib);
            end
            a = W'(ia); b = W'(ib); start_valid = 1'b1;
            if (ib == 0) exp_q.push_back({4'hF, W'(ia), 1'b1});
            else exp_q.push_back({W'(ia / ib), W'(ia % ib), 1'b0});
          end
        end
        @(negedge clk);
        start_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin : monitor
        int cyc;
        logic rr;
        logic [2*W:0] e;
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          rr = ($urandom_range(0, 3) != 0);
          res_ready = rr;
          if (res_valid && rr) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL ex_extra_result: got %0h expected none", {quot, rem, div_by_zero});
            end else begin
              e = exp_q.pop_front();
              check("ex_result", {quot, rem, div_by_zero}, e);
            end
            got++;
          end
        end
      end
    join
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("ex_driver_done", drv_done, 1);
    check("ex_result_count", got, 256);
    check("ex_queue_empty", exp_q.size(), 0);
    check("ex_no_extra_valid", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
